// File: rtl/multi_range_trace_capture_if.sv
// AXI-Stream link carrying {pc, instr} trace packets from the capture block to the DMA FIFO.
interface multi_range_trace_capture_if #(
    parameter int unsigned XLEN = 64
) ();
    logic              tvalid;
    logic              tready;
    logic [XLEN+31:0]  tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/multi_range_trace_capture.sv
// Commit-trace filter: start/end trigger FSM, NUM_RANGES address windows, packet FIFO, AXIS out.
// Optional MRTC_DROP_COUNTER_EN adds a saturating dropped_count output.
module multi_range_trace_capture #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NUM_RANGES = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] WFI_INSTR  = 32'h10500073
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   instr,
    input  logic [XLEN-1:0]               pc,
    input  logic                          pc_valid,
    input  logic                          en,
    input  logic [7:0]                    ctrl_addr,
    input  logic [63:0]                   ctrl_wdata,
    input  logic                          ctrl_write_enable,
    input  logic [31:0]                   tlast_interval,
    multi_range_trace_capture_if.master   M_AXIS,
    output logic [1:0]                    trace_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef MRTC_DROP_COUNTER_EN
    ,
    output logic [31:0]                   dropped_count
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = XLEN + 32;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        TRACE      = 2'd1,
        HALTED     = 2'd2
    } state_t;

    state_t              state;
    logic                start_en;
    logic                end_en;
    logic [XLEN-1:0]     start_addr;
    logic [XLEN-1:0]     end_addr;
    logic [NUM_RANGES-1:0] range_mask;
    logic [XLEN-1:0]     range_lo [NUM_RANGES];
    logic [XLEN-1:0]     range_hi [NUM_RANGES];

    logic [DW:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [31:0]         tlast_cnt;
    logic                tvalid_q;

    logic                range_hit_c;
    logic                range_pass_c;
    logic                event_c;
    logic                is_wfi_c;
    logic                start_hit_c;
    logic                end_hit_c;
    logic                qualify_c;
    logic                accept_c;
    logic                full_c;
    logic                pop_c;
    logic                push_c;
    logic                tlast_c;
    logic                restart_c;
    logic [CW-1:0]       count_nxt_c;

    // Control register file; events this cycle still see the old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_en   <= 1'b0;
            end_en     <= 1'b0;
            start_addr <= '0;
            end_addr   <= '1;
            range_mask <= '0;
            for (int i = 0; i < NUM_RANGES; i++) begin
                range_lo[i] <= '0;
                range_hi[i] <= '1;
            end
        end else if (ctrl_write_enable) begin
            if (ctrl_addr == 8'h00) start_en   <= ctrl_wdata[0];
            if (ctrl_addr == 8'h01) end_en     <= ctrl_wdata[0];
            if (ctrl_addr == 8'h02) start_addr <= XLEN'(ctrl_wdata);
            if (ctrl_addr == 8'h03) end_addr   <= XLEN'(ctrl_wdata);
            if (ctrl_addr == 8'h08) range_mask <= ctrl_wdata[NUM_RANGES-1:0];
            for (int i = 0; i < NUM_RANGES; i++) begin
                if (ctrl_addr == 8'(16 + 2 * i)) range_lo[i] <= XLEN'(ctrl_wdata);
                if (ctrl_addr == 8'(17 + 2 * i)) range_hi[i] <= XLEN'(ctrl_wdata);
            end
        end
    end

    // Inclusive window match; an inverted window (lo > hi) can never satisfy both bounds.
    always_comb begin
        range_hit_c = 1'b0;
        for (int i = 0; i < NUM_RANGES; i++) begin
            if (range_mask[i] && (pc >= range_lo[i]) && (pc <= range_hi[i])) range_hit_c = 1'b1;
        end
    end

    assign range_pass_c = (range_mask == '0) | range_hit_c;
    assign event_c      = pc_valid & en;
    assign is_wfi_c     = (instr == WFI_INSTR);
    assign start_hit_c  = ~start_en | (pc == start_addr);
    assign end_hit_c    = end_en & (pc == end_addr);
    assign restart_c    = ctrl_write_enable & (ctrl_addr == 8'h04);
    assign qualify_c    = (state == TRACE) | ((state == WAIT_START) & start_hit_c);
    assign accept_c     = event_c & range_pass_c & qualify_c;
    assign full_c       = (fifo_count == CW'(FIFO_DEPTH));
    assign pop_c        = tvalid_q & M_AXIS.tready;
    assign push_c       = accept_c & (~full_c | pop_c);
    assign tlast_c      = is_wfi_c | ((tlast_interval != 32'd0) && ((tlast_cnt + 32'd1) == tlast_interval));

    always_comb begin
        count_nxt_c = fifo_count;
        if (push_c && !pop_c)      count_nxt_c = fifo_count + CW'(1);
        else if (pop_c && !push_c) count_nxt_c = fifo_count - CW'(1);
    end

    // Trigger state machine; WFI wins over an end match in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_START;
        end else begin
            case (state)
                WAIT_START: if (event_c && start_hit_c) state <= TRACE;
                TRACE: begin
                    if (event_c) begin
                        if (is_wfi_c)       state <= HALTED;
                        else if (end_hit_c) state <= WAIT_START;
                    end
                end
                HALTED:     if (restart_c) state <= WAIT_START;
                default:    state <= WAIT_START;
            endcase
        end
    end

    // Packet FIFO and tlast interval counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tvalid_q   <= 1'b0;
            tlast_cnt  <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= {tlast_c, pc, instr};
                wr_ptr      <= wr_ptr + AW'(1);
                tlast_cnt   <= tlast_c ? 32'd0 : tlast_cnt + 32'd1;
            end
            if (pop_c) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= count_nxt_c;
            tvalid_q   <= (count_nxt_c != '0);
        end
    end

`ifdef MRTC_DROP_COUNTER_EN
    logic drop_c;
    assign drop_c = accept_c & full_c & ~pop_c;

    // Saturating count of packets lost to a full FIFO; restart also clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  dropped_count <= '0;
        else if (restart_c)                          dropped_count <= '0;
        else if (drop_c && (dropped_count != '1))    dropped_count <= dropped_count + 32'd1;
    end
`endif

    assign trace_state   = state;
    assign M_AXIS.tvalid = tvalid_q;
    assign M_AXIS.tdata  = mem[rd_ptr][DW-1:0];
    assign M_AXIS.tlast  = mem[rd_ptr][DW];

endmodule

// File: tb/tb_multi_range_trace_capture.sv
// Bench for multi_range_trace_capture: queue-based reference model, directed scenarios, random soak.
module tb_multi_range_trace_capture;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NR    = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] WFI   = 32'h10500073;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic              pc_valid;
    logic              en;
    logic [7:0]        ctrl_addr;
    logic [63:0]       ctrl_wdata;
    logic              ctrl_write_enable;
    logic [31:0]       tlast_interval;
    logic [1:0]        trace_state;
    logic [4:0]        fifo_count;
`ifdef MRTC_DROP_COUNTER_EN
    logic [31:0]       dropped_count;
`endif

    multi_range_trace_capture_if #(.XLEN(XLEN)) axis ();

    multi_range_trace_capture #(
        .XLEN(XLEN), .NUM_RANGES(NR), .FIFO_DEPTH(DEPTH), .WFI_INSTR(WFI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .pc(pc), .pc_valid(pc_valid), .en(en),
        .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_write_enable(ctrl_write_enable),
        .tlast_interval(tlast_interval), .M_AXIS(axis),
        .trace_state(trace_state), .fifo_count(fifo_count)
`ifdef MRTC_DROP_COUNTER_EN
        , .dropped_count(dropped_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [1:0]   m_state;
    bit           m_start_en, m_end_en;
    logic [63:0]  m_start, m_end;
    logic [3:0]   m_mask;
    logic [63:0]  m_lo [NR];
    logic [63:0]  m_hi [NR];
    logic [96:0]  m_q [$];
    logic [31:0]  m_tcnt;
    logic [31:0]  m_drop;
    logic [64:0]  dut_seen [$];
    logic [64:0]  exp_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0; m_start_en = 0; m_end_en = 0;
        m_start = '0; m_end = '1; m_mask = '0;
        for (int i = 0; i < NR; i++) begin m_lo[i] = '0; m_hi[i] = '1; end
        m_q.delete(); m_tcnt = '0; m_drop = '0;
    endtask

    // Model advances one clock edge from the rules: qualify, pop, push-or-drop, then control write.
    always @(posedge clk) begin : model
        bit ev, wfi, pass, qual, accept, pop, tl;
        logic [1:0] nstate;
        if (rst_n) begin
            if (axis.tvalid && axis.tready) dut_seen.push_back({axis.tlast, axis.tdata[95:32]});
            ev = pc_valid && en;
            wfi = (instr == WFI);
            pass = (m_mask == 0);
            for (int i = 0; i < NR; i++)
                if (m_mask[i] && pc >= m_lo[i] && pc <= m_hi[i]) pass = 1;
            qual = 0; nstate = m_state;
            if (m_state == 2'd0) begin
                if (ev && (!m_start_en || pc == m_start)) begin qual = 1; nstate = 2'd1; end
            end else if (m_state == 2'd1) begin
                if (ev) begin
                    qual = 1;
                    if (wfi) nstate = 2'd2;
                    else if (m_end_en && pc == m_end) nstate = 2'd0;
                end
            end else begin
                if (ctrl_write_enable && ctrl_addr == 8'h04) nstate = 2'd0;
            end
            accept = ev && pass && qual;
            pop = (m_q.size() > 0) && axis.tready;
            if (pop) void'(m_q.pop_front());
            if (accept) begin
                if (m_q.size() < DEPTH) begin
                    tl = wfi || (tlast_interval != 0 && (m_tcnt + 32'd1) == tlast_interval);
                    m_q.push_back({tl, pc, instr});
                    m_tcnt = tl ? 32'd0 : m_tcnt + 32'd1;
                end else if (m_drop != 32'hFFFFFFFF) begin
                    m_drop = m_drop + 1;
                end
            end
            if (ctrl_write_enable) begin
                case (ctrl_addr)
                    8'h00: m_start_en = ctrl_wdata[0];
                    8'h01: m_end_en   = ctrl_wdata[0];
                    8'h02: m_start    = ctrl_wdata;
                    8'h03: m_end      = ctrl_wdata;
                    8'h04: m_drop     = '0;
                    8'h08: m_mask     = ctrl_wdata[3:0];
                    default: begin
                        for (int i = 0; i < NR; i++) begin
                            if (ctrl_addr == 8'(16 + 2 * i)) m_lo[i] = ctrl_wdata;
                            if (ctrl_addr == 8'(17 + 2 * i)) m_hi[i] = ctrl_wdata;
                        end
                    end
                endcase
            end
            m_state = nstate;
        end
    end

    // Compare process: every cycle out of reset, DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("tvalid", 128'(axis.tvalid), 128'(m_q.size() != 0));
            chk("fifo_count", 128'(fifo_count), 128'(m_q.size()));
            chk("trace_state", 128'(trace_state), 128'(m_state));
            if (m_q.size() != 0) begin
                chk("tdata", 128'(axis.tdata), 128'(m_q[0][95:0]));
                chk("tlast", 128'(axis.tlast), 128'(m_q[0][96]));
            end
`ifdef MRTC_DROP_COUNTER_EN
            chk("dropped_count", 128'(dropped_count), 128'(m_drop));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        pc_valid = 0; ctrl_write_enable = 0;
        repeat (n) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        pc_valid = 0; ctrl_write_enable = 1; ctrl_addr = a; ctrl_wdata = d;
        tick();
        ctrl_write_enable = 0;
    endtask

    task automatic send(input logic [63:0] p, input logic [31:0] i);
        ctrl_write_enable = 0; pc_valid = 1; pc = p; instr = i;
        tick();
        pc_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("rst tvalid", 128'(axis.tvalid), 128'(0));
        chk("rst fifo_count", 128'(fifo_count), 128'(0));
        chk("rst trace_state", 128'(trace_state), 128'(0));
        @(negedge clk);
        #2 rst_n = 1;
    endtask

    task automatic check_seen(input string name);
        chk({name, " beats"}, 128'(dut_seen.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < dut_seen.size(); i++)
            chk({name, " beat"}, 128'(dut_seen[i]), 128'(exp_q[i]));
        dut_seen.delete(); exp_q.delete();
    endtask

    initial begin
        rst_n = 0; instr = '0; pc = '0; pc_valid = 0; en = 1;
        ctrl_addr = '0; ctrl_wdata = '0; ctrl_write_enable = 0; tlast_interval = 0;
        axis.tready = 1;
        model_reset();
        #1;
        chk("reset tvalid", 128'(axis.tvalid), 128'(0));
        chk("reset tdata", 128'(axis.tdata), 128'(0));
        chk("reset tlast", 128'(axis.tlast), 128'(0));
        chk("reset fifo_count", 128'(fifo_count), 128'(0));
        chk("reset trace_state", 128'(trace_state), 128'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1;

        // Free-run
        tick();
        chk("free tvalid before", 128'(axis.tvalid), 128'(0));
        send(64'h1000, NOP);
        chk("free tvalid after first push", 128'(axis.tvalid), 128'(1));
        chk("free first tdata", 128'(axis.tdata), 128'({64'h1000, NOP}));
        for (int k = 1; k < 5; k++) send(64'h1000 + 64'(4 * k), NOP);
        idle(3);
        for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, 64'h1000 + 64'(4 * k)});
        check_seen("free-run");

        // Start/end triggers
        do_reset();
        wr(8'h00, 1); wr(8'h01, 1); wr(8'h02, 64'h2000); wr(8'h03, 64'h2008);
        send(64'h1FFC, NOP);
        chk("trig state wait", 128'(trace_state), 128'(0));
        send(64'h2000, NOP);
        chk("trig state trace", 128'(trace_state), 128'(1));
        send(64'h2004, NOP);
        send(64'h2008, NOP);
        chk("trig state end", 128'(trace_state), 128'(0));
        send(64'h200C, NOP);
        idle(3);
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 64'h2000 + 64'(4 * k)});
        check_seen("triggers");

        // Multi-range
        wr(8'h00, 0);
        wr(8'h10, 64'h100); wr(8'h11, 64'h1FF); wr(8'h14, 64'h400); wr(8'h15, 64'h4FF);
        wr(8'h08, 64'h5);
        send(64'h150, NOP); send(64'h250, NOP); send(64'h480, NOP);
        idle(3);
        exp_q.push_back({1'b0, 64'h150}); exp_q.push_back({1'b0, 64'h480});
        check_seen("multi-range");

        // Backpressure
        wr(8'h08, 0);
        axis.tready = 0;
        for (int k = 0; k < 20; k++) send(64'h3000 + 64'(4 * k), NOP);
        chk("bp fifo_count", 128'(fifo_count), 128'(16));
`ifdef MRTC_DROP_COUNTER_EN
        chk("bp dropped", 128'(dropped_count), 128'(4));
`endif
        axis.tready = 1;
        idle(18);
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b0, 64'h3000 + 64'(4 * k)});
        check_seen("backpressure");

        // Reset mid-operation with non-default control state
        axis.tready = 0;
        wr(8'h08, 64'h5); wr(8'h00, 1); wr(8'h02, 64'h5000);
        for (int k = 0; k < 8; k++) send(64'h150 + 64'(4 * k), NOP);
        chk("pre-reset fifo_count", 128'(fifo_count), 128'(8));
        do_reset();
        dut_seen.delete();
        axis.tready = 1;

        // tlast interval and WFI (default mask/triggers must admit 0xA000..)
        tlast_interval = 3;
        for (int k = 0; k < 7; k++) send(64'hA000 + 64'(4 * k), (k == 6) ? WFI : NOP);
        chk("wfi state halted", 128'(trace_state), 128'(2));
        idle(3);
        for (int k = 0; k < 7; k++)
            exp_q.push_back({(k == 2 || k == 5 || k == 6), 64'hA000 + 64'(4 * k)});
        check_seen("tlast");
        send(64'hB000, NOP);
        idle(2);
        chk("halted ignores fifo_count", 128'(fifo_count), 128'(0));
        check_seen("halted");
        wr(8'h04, 64'hDEAD);
        chk("restart state", 128'(trace_state), 128'(0));
        send(64'hB004, NOP);
        chk("restart trace", 128'(trace_state), 128'(1));
        idle(2);
        exp_q.push_back({1'b0, 64'hB004});
        check_seen("restart");

        // Random soak
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 9) != 0);
            axis.tready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) tlast_interval = 32'($urandom_range(0, 5));
            pc_valid = ($urandom_range(0, 3) != 0);
            pc = 64'($urandom_range(0, 63) * 4);
            instr = ($urandom_range(0, 19) == 0) ? WFI : $urandom();
            ctrl_write_enable = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
                0: ctrl_addr = 8'h00;
                1: ctrl_addr = 8'h01;
                2: ctrl_addr = 8'h02;
                3: ctrl_addr = 8'h03;
                4: ctrl_addr = 8'h04;
                5: ctrl_addr = 8'h08;
                6: ctrl_addr = 8'(16 + $urandom_range(0, 7));
                default: ctrl_addr = 8'($urandom_range(0, 255));
            endcase
            ctrl_wdata = 64'($urandom_range(0, 63) * 4 + $urandom_range(0, 1));
            tick();
        end
        idle(DEPTH + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
